// File: rtl/apbuart_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apbuart_apb_master
// Purpose  : Single-transfer APB master that feeds the UART APB slave port.
//            Optional macro APB_WAIT_EN enables pready_i wait states with a
//            WAIT_MAX-cycle timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module apbuart_apb_master #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic w_accept;
  logic w_done;
  logic w_abort;
  logic w_complete;
  logic w_psel_nxt;
  logic w_penable_nxt;

  assign cmd_ready_o = (r_state == S_IDLE) & ~rst;
  assign w_accept    = cmd_valid_i & cmd_ready_o;

`ifdef APB_WAIT_EN
  localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  logic [CNT_W-1:0] r_wait_cnt;

  assign w_done  = pready_i;
  assign w_abort = ~pready_i & (r_wait_cnt == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_accept) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !pready_i && !w_abort) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end
`else
  // Without wait states every ACCESS phase is a single cycle.
  logic w_unused_pready;
  assign w_unused_pready = pready_i | (WAIT_MAX == 0);
  assign w_done          = 1'b1;
  assign w_abort         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_done || w_abort) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_complete    = (r_state == S_ACCESS) & (w_done | w_abort);
    w_psel_nxt    = (w_state_nxt != S_IDLE);
    w_penable_nxt = (w_state_nxt == S_ACCESS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_rsp_valid <= w_complete;
      if (w_accept) begin
        r_pwrite <= cmd_write_i;
        r_paddr  <= cmd_addr_i;
        r_pwdata <= cmd_wdata_i;
      end
      if (w_complete) begin
        r_rsp_err <= w_abort | pslverr_i;
        // A timeout keeps the previous read data.
        if (!r_pwrite && !w_abort) r_rsp_rdata <= prdata_i;
      end
    end
  end

  assign psel_o      = r_psel;
  assign penable_o   = r_penable;
  assign pwrite_o    = r_pwrite;
  assign paddr_o     = r_paddr;
  assign pwdata_o    = r_pwdata;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_apbuart_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apbuart_apb_master
// Purpose  : Self-checking bench for apbuart_apb_master (vector table plus
//            hand-written latency, throughput and APB_WAIT_EN sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apbuart_apb_master;

`ifdef APB_WAIT_EN
  localparam int WM = 4;
`else
  localparam int WM = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b1;
  logic        pslverr = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  apbuart_apb_master #(.ADDR_W(8), .DATA_W(32), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  typedef struct {
    logic        rst, v, w;
    logic [7:0]  a;
    logic [31:0] wd, prd;
    logic        err;
    logic        e_rdy, e_psel, e_pen, e_pw;
    logic [7:0]  e_pa;
    logic [31:0] e_pd;
    logic        e_rv, e_re;
    logic [31:0] e_rd;
  } vec_t;

  localparam int NV = 23;
  vec_t tv[NV];

  function automatic vec_t mk(logic r, logic v, logic w, logic [7:0] a, logic [31:0] wd,
                              logic [31:0] prd, logic err, logic rdy, logic ps, logic pe,
                              logic pw, logic [7:0] pa, logic [31:0] pd, logic rv,
                              logic re, logic [31:0] rd);
    vec_t t;
    t.rst = r; t.v = v; t.w = w; t.a = a; t.wd = wd; t.prd = prd; t.err = err;
    t.e_rdy = rdy; t.e_psel = ps; t.e_pen = pe; t.e_pw = pw; t.e_pa = pa;
    t.e_pd = pd; t.e_rv = rv; t.e_re = re; t.e_rd = rd;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Protocol monitor: every enable phase follows a select-only cycle.
  logic r_prev_pen  = 1'b0;
  logic r_prev_psel = 1'b0;
  always @(negedge clk) begin
    if (penable === 1'b1) begin
`ifdef APB_WAIT_EN
      chk("pen_after_psel", 0, {31'd0, r_prev_psel}, 32'd1);
`else
      chk("pen_single", 0, {30'd0, r_prev_pen, r_prev_psel}, 32'd1);
`endif
    end
    r_prev_pen  <= penable;
    r_prev_psel <= psel;
  end

`ifdef APB_WAIT_EN
  task automatic run_wait(input int low_cycles, output int pen_cnt, output logic err,
                          output logic got_rsp);
    pen_cnt = 0; got_rsp = 1'b0; err = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h60; cmd_wdata = 32'h66;
    pready = 1'b0;
    for (int k = 0; k < 40 && !got_rsp; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (penable) pen_cnt++;
      if (rsp_valid) begin got_rsp = 1'b1; err = rsp_err; end
      pready = (pen_cnt >= low_cycles);
    end
    pready = 1'b1;
  endtask
`endif

  initial begin
    int   lat;
    int   pulses;
    logic done;
    tv[0]  = mk(1,1,1,8'h10,32'h99,0,0,            0,0,0,0,8'h00,32'h0,   0,0,32'h0);
    tv[1]  = tv[0];
    tv[2]  = tv[0];
    tv[3]  = mk(0,1,1,8'h04,32'h41,0,0,            0,1,0,1,8'h04,32'h41,  0,0,32'h0);
    tv[4]  = mk(0,0,0,8'h00,32'h0,0,0,             0,1,1,1,8'h04,32'h41,  0,0,32'h0);
    tv[5]  = mk(0,0,0,8'h00,32'h0,0,0,             1,0,0,1,8'h04,32'h41,  1,0,32'h0);
    tv[6]  = mk(0,1,0,8'h08,32'h1234,0,0,          0,1,0,0,8'h08,32'h1234,0,0,32'h0);
    tv[7]  = mk(0,0,0,8'h00,32'h0,0,0,             0,1,1,0,8'h08,32'h1234,0,0,32'h0);
    tv[8]  = mk(0,0,0,8'h00,32'h0,32'hA5A5_0001,0, 1,0,0,0,8'h08,32'h1234,1,0,32'hA5A5_0001);
    tv[9]  = mk(0,0,0,8'h00,32'h0,32'hFFFF_FFFF,0, 1,0,0,0,8'h08,32'h1234,0,0,32'hA5A5_0001);
    tv[10] = mk(0,1,1,8'h0C,32'h11,0,0,            0,1,0,1,8'h0C,32'h11,  0,0,32'hA5A5_0001);
    tv[11] = mk(0,1,0,8'h20,32'h22,0,0,            0,1,1,1,8'h0C,32'h11,  0,0,32'hA5A5_0001);
    tv[12] = mk(0,1,0,8'h20,32'h22,32'h55,0,       1,0,0,1,8'h0C,32'h11,  1,0,32'hA5A5_0001);
    tv[13] = mk(0,1,0,8'h20,32'h22,0,0,            0,1,0,0,8'h20,32'h22,  0,0,32'hA5A5_0001);
    tv[14] = mk(0,1,1,8'h30,32'h33,0,0,            0,1,1,0,8'h20,32'h22,  0,0,32'hA5A5_0001);
    tv[15] = mk(0,1,1,8'h30,32'h33,32'h00C0_FFEE,1,1,0,0,0,8'h20,32'h22,  1,1,32'h00C0_FFEE);
    tv[16] = mk(0,1,1,8'h30,32'h33,0,0,            0,1,0,1,8'h30,32'h33,  0,1,32'h00C0_FFEE);
    tv[17] = mk(0,0,0,8'h00,32'h0,0,0,             0,1,1,1,8'h30,32'h33,  0,1,32'h00C0_FFEE);
    tv[18] = mk(0,0,0,8'h00,32'h0,0,0,             1,0,0,1,8'h30,32'h33,  1,0,32'h00C0_FFEE);
    tv[19] = mk(0,1,0,8'h40,32'h44,0,0,            0,1,0,0,8'h40,32'h44,  0,0,32'h00C0_FFEE);
    tv[20] = mk(0,0,0,8'h00,32'h0,0,0,             0,1,1,0,8'h40,32'h44,  0,0,32'h00C0_FFEE);
    tv[21] = mk(1,0,0,8'h00,32'h0,32'h77,1,        0,0,0,0,8'h00,32'h0,   0,0,32'h0);
    tv[22] = mk(0,0,0,8'h00,32'h0,0,0,             1,0,0,0,8'h00,32'h0,   0,0,32'h0);

    // Each row: drive inputs, take one edge, check the registered result.
    for (int i = 0; i < NV; i++) begin
      rst = tv[i].rst; cmd_valid = tv[i].v; cmd_write = tv[i].w; cmd_addr = tv[i].a;
      cmd_wdata = tv[i].wd; prdata = tv[i].prd; pslverr = tv[i].err; pready = 1'b1;
      @(posedge clk); #1;
      chk("cmd_ready", i, {31'd0, cmd_ready}, {31'd0, tv[i].e_rdy});
      chk("psel",      i, {31'd0, psel},      {31'd0, tv[i].e_psel});
      chk("penable",   i, {31'd0, penable},   {31'd0, tv[i].e_pen});
      chk("pwrite",    i, {31'd0, pwrite},    {31'd0, tv[i].e_pw});
      chk("paddr",     i, {24'd0, paddr},     {24'd0, tv[i].e_pa});
      chk("pwdata",    i, pwdata,             tv[i].e_pd);
      chk("rsp_valid", i, {31'd0, rsp_valid}, {31'd0, tv[i].e_rv});
      chk("rsp_err",   i, {31'd0, rsp_err},   {31'd0, tv[i].e_re});
      chk("rsp_rdata", i, rsp_rdata,          tv[i].e_rd);
    end

    // Acceptance-to-response latency for a read.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h50; cmd_wdata = 32'h0;
    prdata = 32'h1234_5678; pslverr = 1'b0;
    lat = 0; done = 1'b0;
    for (int k = 1; k <= 10 && !done; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (rsp_valid) begin lat = k; done = 1'b1; end
    end
    chk("latency", 0, lat, 32'd3);
    chk("lat_rdata", 0, rsp_rdata, 32'h1234_5678);

    // Continuous valid: three transfers in nine edges, then idle.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h70; cmd_wdata = 32'h7;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
      if (k == 9) cmd_valid = 1'b0;
    end
    chk("b2b_pulses", 0, pulses, 32'd3);
    chk("b2b_idle_psel", 0, {31'd0, psel}, 32'd0);

`ifdef APB_WAIT_EN
    begin
      int   pc;
      logic e;
      logic got;
      run_wait(2, pc, e, got);
      chk("wait_rsp", 0, {31'd0, got}, 32'd1);
      chk("wait_pen_cycles", 0, pc, 32'd3);
      chk("wait_err", 0, {31'd0, e}, 32'd0);
      @(posedge clk); #1;
      run_wait(1000, pc, e, got);
      chk("abort_rsp", 0, {31'd0, got}, 32'd1);
      chk("abort_pen_cycles", 0, pc, 32'd4);
      chk("abort_err", 0, {31'd0, e}, 32'd1);
      chk("abort_rdata", 0, rsp_rdata, 32'h1234_5678);
    end
`endif

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apbuart_apb_master.md
Name: apbuart_apb_master

Overview:
APB master stage that sits directly upstream of the UART's APB slave port and drives psel/penable/pwrite/paddr/pwdata into it. It accepts single read/write commands from a valid/ready command port and runs exactly one non-burst APB transfer per command. It returns read data and error status on a one-cycle response strobe. Its bus output must satisfy the UART's APB protocol checks:
- penable rises the cycle after psel rises.
- psel and penable fall together.
- penable is high for exactly one cycle in the base build.
- pwrite is stable while penable rises.

Parameters:
ADDR_W, 8, width of paddr_o and cmd_addr_i
DATA_W, 32, width of pwdata_o, prdata_i, cmd_wdata_i, rsp_rdata_o
WAIT_MAX, 16, max ACCESS cycles waiting for pready_i (used only with APB_WAIT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when valid&ready
cmd_write_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_W  transfer address
cmd_wdata_i  in  DATA_W  write data
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
paddr_o  out  ADDR_W  APB address
pwdata_o  out  DATA_W  APB write data
prdata_i  in  DATA_W  APB read data
pready_i  in  1  APB ready (ignored unless APB_WAIT_EN)
pslverr_i  in  1  APB slave error
rsp_valid_o  out  1  one-cycle completion pulse
rsp_rdata_o  out  DATA_W  captured read data
rsp_err_o  out  1  error flag for the completed transfer

Behaviour:
- All outputs are registered except cmd_ready_o. cmd_ready_o = (state==IDLE) & ~rst.
- Reset (synchronous, any state): the next edge forces state IDLE and clears psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o, rsp_rdata_o, rsp_err_o and the wait counter to 0. A transfer in flight is abandoned with no response.
- FSM states are IDLE, SETUP, ACCESS.
- IDLE:
  - psel_o=0, penable_o=0.
  - On cmd_valid_i & cmd_ready_o, latch write/addr/wdata into pwrite_o/paddr_o/pwdata_o and go to SETUP.
  - Without a command, stay in IDLE.
- SETUP (exactly 1 cycle): psel_o=1, penable_o=0, then go to ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1.
  - Transfer completes at the end of the first ACCESS cycle (base build).
  - On completion, go to IDLE. Next cycle: psel_o=0, penable_o=0, rsp_valid_o=1.
  - rsp_err_o = pslverr_i sampled at completion.
  - rsp_rdata_o = prdata_i if read; unchanged if write.
- rsp_valid_o is high for exactly 1 cycle per completed transfer. rsp_rdata_o and rsp_err_o hold until the next completion.
- pwrite_o, paddr_o, pwdata_o change only on command acceptance. They are stable through SETUP, ACCESS and the following IDLE.
- Throughput: a command accepted in the rsp_valid_o cycle is legal, since state is IDLE. Minimum spacing is 3 cycles per transfer. psel_o is always low for at least 1 cycle between transfers; there are no back-to-back ACCESS phases.
- Latency: acceptance edge to rsp_valid_o high is 3 edges (SETUP, ACCESS, IDLE+rsp).
- cmd_* inputs are ignored outside IDLE. A cmd_valid_i held during a transfer is accepted at the next IDLE.

Optional Feature:
Macro APB_WAIT_EN.
- Defined:
  - ACCESS holds until pready_i=1; a wait counter increments each ACCESS cycle with pready_i=0.
  - Completion occurs on pready_i=1, with rsp_err_o=pslverr_i.
  - If the counter reaches WAIT_MAX-1 with pready_i still 0, the transfer is aborted: go to IDLE, rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o unchanged.
  - The counter clears on entering SETUP.
- Not defined: pready_i is unused and ACCESS is always exactly 1 cycle. The no-burst property then holds by construction.

Test Plan:
- Reset: rst=1 for 3 cycles with cmd_valid_i=1 -> psel_o=penable_o=rsp_valid_o=0 and cmd_ready_o=0 throughout. First accept occurs on the first cycle after rst falls.
- Write: addr=0x04, wdata=0x0000_0041 -> SETUP: psel=1/penable=0; ACCESS: psel=1/penable=1/pwrite=1/paddr=0x04/pwdata=0x41. Next cycle: both low, rsp_valid=1, rsp_err=0.
- Read: addr=0x08, prdata_i=0xA5A5_0001 during ACCESS -> rsp_rdata_o=0xA5A5_0001 on the rsp_valid cycle, held after. pwrite_o=0 is stable from SETUP through completion.
- Back-to-back: cmd_valid_i held high for 3 commands -> psel_o pattern 0,1,1,0,1,1,0,1,1,0. Exactly 3 rsp_valid pulses. No cycle has penable high for 2 consecutive cycles.
- Error and reset mid-transfer:
  - pslverr_i=1 in ACCESS -> rsp_err_o=1.
  - rst asserted in ACCESS -> next cycle all outputs 0 and no rsp_valid pulse.
- APB_WAIT_EN (WAIT_MAX=4):
  - pready_i low 2 cycles then high -> penable high for 3 cycles, normal response.
  - pready_i never high -> abort after 4 ACCESS cycles with rsp_err_o=1.
